// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit: AND/OR/XOR/ANDN over WIDTH bits,
// CHUNK bits per cycle, with start/ready/done handshake and zero flag.
module logic_unit_iter #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_chk
        $error("logic_unit_iter: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] full_op;
    logic [WIDTH-1:0] shadow_nx;

    always_comb begin
        full_op = '0;
        unique case (op_q)
            2'b00:   full_op = a_q & b_q;
            2'b01:   full_op = a_q | b_q;
            2'b10:   full_op = a_q ^ b_q;
            2'b11:   full_op = a_q & ~b_q;
            default: full_op = '0;
        endcase
    end

    // Only the active chunk of the shadow is refreshed each RUN cycle.
    always_comb begin
        shadow_nx = shadow_q;
        shadow_nx[int'(cnt_q)*CHUNK +: CHUNK] =
            full_op[int'(cnt_q)*CHUNK +: CHUNK];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        result_d = result_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shadow_d = shadow_nx;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = shadow_nx;
                    zero_d   = (shadow_nx == '0);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_logic_unit_iter.sv
// Directed bench for logic_unit_iter: 64/16, 32/32 and 8/2 instances
// with hand-computed vectors and a bitwise reference for the sweep.
module tb_logic_unit_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  start_v = '0;
    logic [1:0]  op_v [3];
    logic [63:0] a_v [3];
    logic [63:0] b_v [3];
    logic [2:0]  ready_v;
    logic [2:0]  done_v;
    logic [2:0]  zero_v;
    logic [63:0] res0;
    logic [31:0] res1;
    logic [7:0]  res2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_unit_iter #(.WIDTH(64), .CHUNK(16)) u_d0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .op(op_v[0]),
        .A(a_v[0]), .B(b_v[0]), .ready(ready_v[0]), .done(done_v[0]),
        .result(res0), .zero(zero_v[0])
    );

    logic_unit_iter #(.WIDTH(32), .CHUNK(32)) u_d1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .op(op_v[1]),
        .A(a_v[1][31:0]), .B(b_v[1][31:0]), .ready(ready_v[1]),
        .done(done_v[1]), .result(res1), .zero(zero_v[1])
    );

    logic_unit_iter #(.WIDTH(8), .CHUNK(2)) u_d2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .op(op_v[2]),
        .A(a_v[2][7:0]), .B(b_v[2][7:0]), .ready(ready_v[2]),
        .done(done_v[2]), .result(res2), .zero(zero_v[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] get_res(input int d);
        case (d)
            0:       return res0;
            1:       return {32'h0, res1};
            default: return {56'h0, res2};
        endcase
    endfunction

    function automatic logic [63:0] ref_op(input logic [1:0] o,
                                           input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int w);
        logic [63:0] r;
        logic [63:0] m;
        case (o)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = a & ~b;
        endcase
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        return r & m;
    endfunction

    task automatic do_op(input int d, input logic [1:0] o,
                         input logic [63:0] a, input logic [63:0] b,
                         input int lat, input logic [63:0] exp,
                         input string tag);
        int edges;
        start_v[d] = 1'b1;
        op_v[d] = o;
        a_v[d] = a;
        b_v[d] = b;
        tick();
        start_v[d] = 1'b0;
        chk({tag, "_busy"}, {63'h0, ready_v[d]}, 64'd0);
        edges = 0;
        while (!done_v[d] && edges < lat + 4) begin
            tick();
            edges++;
        end
        chk({tag, "_lat"}, 64'(edges), 64'(lat));
        chk({tag, "_res"}, get_res(d), exp);
        chk({tag, "_zero"}, {63'h0, zero_v[d]}, {63'h0, exp == 64'd0});
        tick();
        chk({tag, "_pulse"}, {63'h0, done_v[d]}, 64'd0);
    endtask

    localparam logic [63:0] VA = 64'hFFFF0000FFFF0000;
    localparam logic [63:0] VB = 64'h0F0F0F0F0F0F0F0F;
    localparam logic [63:0] AA = 64'hAAAAAAAAAAAAAAAA;

    initial begin
        logic [1:0]  ro;
        logic [63:0] ra;
        logic [63:0] rb;
        int          dd;
        logic        seen;

        for (int i = 0; i < 3; i++) begin
            op_v[i] = '0;
            a_v[i] = '0;
            b_v[i] = '0;
        end

        start_v = 3'b111;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", {63'h0, ready_v[i]}, 64'd1);
            chk("rst_done", {63'h0, done_v[i]}, 64'd0);
            chk("rst_res", get_res(i), 64'd0);
        end
        tick();
        tick();
        reset = 1'b0;
        start_v = '0;
        tick();
        tick();
        chk("idle_ready", {63'h0, ready_v[0]}, 64'd1);
        chk("idle_done", {63'h0, done_v[0]}, 64'd0);
        chk("idle_res", res0, 64'd0);
        chk("idle_zero", {63'h0, zero_v[0]}, 64'd0);

        do_op(0, 2'b00, VA, VB, 4, 64'h0F0F00000F0F0000, "and");
        do_op(0, 2'b01, VA, VB, 4, 64'hFFFF0F0FFFFF0F0F, "or");
        do_op(0, 2'b10, VA, VB, 4, 64'hF0F00F0FF0F00F0F, "xor");
        do_op(0, 2'b11, VA, VB, 4, 64'hF0F00000F0F00000, "andn");
        do_op(0, 2'b11, AA, AA, 4, 64'd0, "andn_z");
        do_op(0, 2'b00, 64'd1, 64'd1, 4, 64'd1, "and_one");

        // Start pulse and operand churn during RUN must be ignored.
        start_v[0] = 1'b1;
        op_v[0] = 2'b00;
        a_v[0] = VA;
        b_v[0] = VB;
        tick();
        start_v[0] = 1'b0;
        tick();
        start_v[0] = 1'b1;
        op_v[0] = 2'b01;
        a_v[0] = 64'h1234;
        b_v[0] = 64'h5678;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        chk("busy_done", {63'h0, done_v[0]}, 64'd1);
        chk("busy_res", res0, 64'h0F0F00000F0F0000);
        tick();
        chk("busy_idle", {63'h0, ready_v[0] & ~done_v[0]}, 64'd1);

        // Back-to-back: start held high through the first DONE.
        start_v[0] = 1'b1;
        op_v[0] = 2'b00;
        a_v[0] = VA;
        b_v[0] = VB;
        tick();
        op_v[0] = 2'b01;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 5) start_v[0] = 1'b0;
            chk($sformatf("b2b_done%0d", e), {63'h0, done_v[0]},
                {63'h0, (e == 4 || e == 9)});
            chk($sformatf("b2b_rdy%0d", e), {63'h0, ready_v[0]},
                {63'h0, (e == 4 || e == 9 || e == 10)});
            if (e == 4 || e == 6)
                chk("b2b_res1", res0, 64'h0F0F00000F0F0000);
            if (e == 9)
                chk("b2b_res2", res0, 64'hFFFF0F0FFFFF0F0F);
        end

        // Reset two edges after accept aborts the operation.
        start_v[0] = 1'b1;
        op_v[0] = 2'b10;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_res", res0, 64'd0);
        chk("abort_ready", {63'h0, ready_v[0]}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= done_v[0];
        end
        chk("abort_nodone", {63'h0, seen}, 64'd0);
        do_op(0, 2'b10, VA, VB, 4, 64'hF0F00F0FF0F00F0F, "after_abort");

        for (int i = 0; i < 12; i++) begin
            dd = (i < 6) ? 1 : 2;
            ro = 2'($urandom_range(0, 3));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            do_op(dd, ro, ra, rb, (dd == 1) ? 1 : 4,
                  ref_op(ro, ra, rb, (dd == 1) ? 32 : 8),
                  $sformatf("sweep%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/logic_unit_iter.md
# logic_unit_iter

Parametrised, multi-cycle bitwise logic unit for the RISC-V ALU. It replaces the fixed 64-bit single-function AND stage with a block that supports AND, OR, XOR and ANDN at any operand width. It processes operands CHUNK bits per cycle under a start/ready/done handshake, and publishes a registered result with a zero flag. It sits beside the adder in the ALU operations group, and the ALU control FSM drives it.

## Interface
- WIDTH, 64: operand/result width in bits.
- CHUNK, 16: bits processed per cycle. WIDTH % CHUNK != 0 is an elaboration-time error. N = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  reset; one clock, reset is synchronous and active-high.
- start  input  1  request; accepted only on an edge where ready=1.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 ANDN (A & ~B).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ready  output  1  block can accept start this cycle.
- done  output  1  one-cycle pulse; result/zero valid and updated.
- result  output  WIDTH  registered result of last completed operation.
- zero  output  1  result == 0, registered with result.

## Operation
- Three states:
  - IDLE: ready=1, done=0.
  - RUN: ready=0, done=0.
  - DONE: ready=1, done=1.
- Accept (start=1 while ready=1):
  - A, B and op are latched into internal registers.
  - Chunk counter is cleared to 0.
  - State goes to RUN.
  - Inputs are not sampled again until the next accept.
- RUN, each edge:
  - Shadow bits [k*CHUNK +: CHUNK] = op applied to the latched chunk k.
  - Counter increments.
  - When k = N-1, the full value (including this chunk) is loaded into result, zero is recomputed from it, and state goes to DONE.
- DONE, next edge:
  - If start=1, the new request is accepted and state goes to RUN (back-to-back).
  - Otherwise state goes to IDLE.
- start while in RUN is ignored; no queuing and no effect on the running operation.
- result and zero change only on the RUN→DONE edge. They hold between completions, including across IDLE and the whole next RUN.
- Counter width is max(1, clog2(N)). With N=1, RUN lasts exactly one edge.
- All logic is purely bitwise: no carries, no sign handling. Bits of B beyond the op have no effect.

## Timing
- Reset values:
  - State IDLE, ready=1, done=0.
  - result=0, zero=0.
  - Counter and latched operands are 0.
- Reset has priority over everything. Asserted mid-RUN or in DONE, it aborts the operation with no done pulse and result forced to 0. A start on the same edge as reset is dropped.
- Latency: accept on edge 0, done=1 after edge N, done=0 after edge N+1.
- Throughput: one operation per N+1 cycles with back-to-back start in DONE (accept on the done cycle).
- ready falls after the accepting edge and rises after edge N.
- Changes on A, B or op during RUN never affect the result.

## Test plan
- Reset, 3 cycles:
  - During and after reset: ready=1, done=0, result=0, zero=0.
  - After release, start=0: outputs remain at these values.
- WIDTH=64, CHUNK=16, A=0xFFFF0000FFFF0000, B=0x0F0F0F0F0F0F0F0F:
  - op=00 → result 0x0F0F00000F0F0000, done exactly 4 edges after accept, zero=0.
  - op=01 → 0xFFFF0F0FFFFF0F0F.
  - op=10 → 0xF0F00F0FF0F00F0F.
  - op=11 → 0xF0F00000F0F00000.
- ANDN zero flag: A=B=0xAAAAAAAAAAAAAAAA, op=11 → result 0, zero=1 with done. Then AND with A=B=1 → result 1, zero=0.
- Busy and back-to-back:
  - During RUN, pulse start and change A/B/op → first result unchanged.
  - Hold start high through DONE → second operation accepted on the done cycle, second done 5 cycles after the first, ready=1 only in DONE/IDLE.
- Reset mid-op: assert reset 2 edges after accept → no done pulse, result=0, state IDLE. The next operation completes normally.
- Parameter sweep: WIDTH=32,CHUNK=32 (N=1) and WIDTH=8,CHUNK=2 (N=4) → random A/B/op compared against a bitwise reference model, latency N edges each.
